// File: rtl/truth_table_checker.sv
// Sweeps a shared 4-bit input vector over all codes, samples NIMPL parallel
// implementations and records the golden truth table plus disagreement summary.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | driving vectors, counting settle cycles, sampling
// DONE  | results frozen until start or reset
module truth_table_checker #(
   parameter int NIMPL  = 6,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [3:0]       abcd,
   input  logic [NIMPL-1:0] impl_s,
   output logic             busy,
   output logic             done,
   output logic [15:0]      truth_table,
   output logic [NIMPL-1:0] mismatch_mask,
   output logic [4:0]       mismatch_count,
   output logic [3:0]       first_fail_vec,
   output logic             first_fail_valid
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   state_t           state_q;
   logic [3:0]       settle_q;
   logic [3:0]       abcd_q;
   logic             busy_q;
   logic             done_q;
   logic [15:0]      tt_q;
   logic [NIMPL-1:0] mask_q;
   logic [4:0]       count_q;
   logic [3:0]       ffv_q;
   logic             ffvalid_q;
   logic [NIMPL-1:0] diff_d;

   // Bit 0 compares golden against itself, so mask bit 0 can never be set.
   assign diff_d = impl_s ^ {NIMPL{impl_s[0]}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         settle_q  <= 4'd0;
         abcd_q    <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tt_q      <= 16'd0;
         mask_q    <= '0;
         count_q   <= 5'd0;
         ffv_q     <= 4'd0;
         ffvalid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q   <= ST_RUN;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  abcd_q    <= 4'd0;
                  settle_q  <= SETTLE_C;
                  tt_q      <= 16'd0;
                  mask_q    <= '0;
                  count_q   <= 5'd0;
                  ffv_q     <= 4'd0;
                  ffvalid_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (settle_q != 4'd0) begin
                  settle_q <= settle_q - 4'd1;
               end else begin
                  tt_q[abcd_q] <= impl_s[0];
                  mask_q       <= mask_q | diff_d;
                  if (diff_d != '0) begin
                     count_q <= count_q + 5'd1;
                     if (!ffvalid_q) begin
                        ffv_q     <= abcd_q;
                        ffvalid_q <= 1'b1;
                     end
                  end
                  if (abcd_q == 4'd15) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     abcd_q   <= abcd_q + 4'd1;
                     settle_q <= SETTLE_C;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign abcd             = abcd_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign truth_table      = tt_q;
   assign mismatch_mask    = mask_q;
   assign mismatch_count   = count_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: three checker instances (NIMPL/SETTLE = 6/1, 4/0, 2/3) driving
// behavioural implementations of the golden function 16'h212F.
module tb_truth_table_checker;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [15:0] gold_tt = 16'h212F;

   logic start_a, start_b, start_c;
   logic [3:0] abcd_a, abcd_b, abcd_c;
   logic [5:0] impl_a;
   logic [3:0] impl_b;
   logic [1:0] impl_c;
   logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic [15:0] tt_a, tt_b, tt_c;
   logic [5:0] mask_a;
   logic [3:0] mask_b;
   logic [1:0] mask_c;
   logic [4:0] cnt_a, cnt_b, cnt_c;
   logic [3:0] ffv_a, ffv_b, ffv_c;
   logic ffok_a, ffok_b, ffok_c;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   bit pulsed;

   // A: four good copies, NAND form stuck at 1, NOR form stuck at 0.
   always_comb impl_a = {1'b0, 1'b1, {4{gold_tt[abcd_a]}}};
   always_comb impl_b = {4{gold_tt[abcd_b]}};
   always_comb impl_c = {gold_tt[abcd_c] ^ (abcd_c == 4'd9), gold_tt[abcd_c]};

   truth_table_checker #(.NIMPL(6), .SETTLE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abcd(abcd_a), .impl_s(impl_a),
      .busy(busy_a), .done(done_a), .truth_table(tt_a), .mismatch_mask(mask_a),
      .mismatch_count(cnt_a), .first_fail_vec(ffv_a), .first_fail_valid(ffok_a));

   truth_table_checker #(.NIMPL(4), .SETTLE(0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abcd(abcd_b), .impl_s(impl_b),
      .busy(busy_b), .done(done_b), .truth_table(tt_b), .mismatch_mask(mask_b),
      .mismatch_count(cnt_b), .first_fail_vec(ffv_b), .first_fail_valid(ffok_b));

   truth_table_checker #(.NIMPL(2), .SETTLE(3)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .abcd(abcd_c), .impl_s(impl_c),
      .busy(busy_c), .done(done_c), .truth_table(tt_c), .mismatch_mask(mask_c),
      .mismatch_count(cnt_c), .first_fail_vec(ffv_c), .first_fail_valid(ffok_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a_results(input string tag);
      chk({tag, "_tt"},    32'(tt_a),   32'h212F);
      chk({tag, "_mask"},  32'(mask_a), 32'b110000);
      chk({tag, "_cnt"},   32'(cnt_a),  32'd16);
      chk({tag, "_ffv"},   32'(ffv_a),  32'd0);
      chk({tag, "_ffok"},  32'(ffok_a), 32'd1);
      chk({tag, "_busy"},  32'(busy_a), 32'd0);
   endtask

   // Issues a one-cycle start on A and counts edges after the start edge until done.
   task automatic sweep_a(output int c);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      c = 0;
      while (!done_a && c < 200) begin
         @(negedge clk);
         c++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_abcd",  32'(abcd_a), 32'd0);
      chk("rst_busy",  32'(busy_a), 32'd0);
      chk("rst_done",  32'(done_a), 32'd0);
      chk("rst_tt",    32'(tt_a),   32'd0);
      chk("rst_ffok",  32'(ffok_a), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // A: stuck-constant NAND/NOR forms, SETTLE=1.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("a_busy_start", 32'(busy_a), 32'd1);
      chk("a_abcd_start", 32'(abcd_a), 32'd0);
      cyc = 0;
      while (!done_a && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("a_cycles", 32'(cyc), 32'd32);
      chk_a_results("a1");
      repeat (3) @(negedge clk);
      chk("a_stable_tt",   32'(tt_a),   32'h212F);
      chk("a_stable_done", 32'(done_a), 32'd1);

      // B: all correct, SETTLE=0, abcd advances every cycle.
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_abcd_0", 32'(abcd_b), 32'd0);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         chk($sformatf("b_abcd_%0d", c), 32'(abcd_b), (c == 16) ? 32'd15 : 32'(c));
         chk($sformatf("b_done_%0d", c), 32'(done_b), (c == 16) ? 32'd1 : 32'd0);
      end
      chk("b_tt",   32'(tt_b),   32'h212F);
      chk("b_mask", 32'(mask_b), 32'd0);
      chk("b_cnt",  32'(cnt_b),  32'd0);
      chk("b_ffok", 32'(ffok_b), 32'd0);

      // C: copy inverted at vector 9 only, SETTLE=3.
      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         chk($sformatf("c_abcd_%0d", c), 32'(abcd_c), (c == 64) ? 32'd15 : 32'(c / 4));
      end
      chk("c_done", 32'(done_c), 32'd1);
      chk("c_tt",   32'(tt_c),   32'h212F);
      chk("c_mask", 32'(mask_c), 32'b10);
      chk("c_cnt",  32'(cnt_c),  32'd1);
      chk("c_ffv",  32'(ffv_c),  32'd9);
      chk("c_ffok", 32'(ffok_c), 32'd1);

      // Asynchronous reset while A is on vector 6.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 0;
      while (abcd_a != 4'd6 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("r_reach6", 32'(abcd_a), 32'd6);
      #2 rst_n = 1'b0;
      #1;
      chk("r_abcd", 32'(abcd_a), 32'd0);
      chk("r_busy", 32'(busy_a), 32'd0);
      chk("r_tt",   32'(tt_a),   32'd0);
      chk("r_mask", 32'(mask_a), 32'd0);
      chk("r_cnt",  32'(cnt_a),  32'd0);
      chk("r_ffok", 32'(ffok_a), 32'd0);
      chk("r_done_c", 32'(done_c), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sweep_a(cyc);
      chk("r_cycles", 32'(cyc), 32'd32);
      chk_a_results("r");

      // start pulsed mid-sweep at vector 4 is ignored.
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 0;
      pulsed = 1'b0;
      while (!done_a && cyc < 200) begin
         if (!pulsed && abcd_a == 4'd4) begin
            start_a = 1'b1;
            pulsed = 1'b1;
         end else begin
            start_a = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start_a = 1'b0;
      chk("i_pulsed", 32'(pulsed), 32'd1);
      chk("i_cycles", 32'(cyc), 32'd32);
      chk_a_results("i");
      sweep_a(cyc);
      chk("i2_cycles", 32'(cyc), 32'd32);
      chk_a_results("i2");

      // start held for 40 cycles on B: back-to-back 17-cycle sweeps.
      @(negedge clk);
      start_b = 1'b1;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         chk($sformatf("h_abcd_%0d", j), 32'(abcd_b), ((j % 17) == 16) ? 32'd15 : 32'(j % 17));
         chk($sformatf("h_done_%0d", j), 32'(done_b), ((j % 17) == 16) ? 32'd1 : 32'd0);
      end
      start_b = 1'b0;
      cyc = 0;
      while (!done_b && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("h_last_done", 32'(done_b), 32'd1);
      chk("h_last_tt",   32'(tt_b),   32'h212F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
